// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   arb_state_t : FSM encoding (IDLE, ACCESS, RESP)
//   req_id_t    : requester index (0 = datapath, 1 = debug/loader)
//   mem_req_t   : latched request payload (addr, wdata, we)
package dmem_arb_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned WE_W            = 4;
  localparam int unsigned MAX_MEM_LATENCY = 4;
  // Wide enough to hold MAX_MEM_LATENCY-1.
  localparam int unsigned CNT_W           = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [WE_W-1:0] we;
  } mem_req_t;

  // Force a byte address onto its containing word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  // Any set low address bit makes a word access misaligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter.
//   valid0/valid1 : request present from requester 0/1
//   last_grant    : id of the requester granted most recently
//   gnt_any_c     : some requester is granted this cycle
//   gnt_id_c      : id of the granted requester (meaningful when gnt_any_c)
// FIXED_PRIO=0 alternates on a tie; FIXED_PRIO=1 always favours requester 0.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_t last_grant,
  output logic    gnt_any_c,
  output req_id_t gnt_id_c
);

  always_comb begin
    gnt_any_c = valid0 | valid1;
    gnt_id_c  = 1'b0;
    if (valid0 && valid1) begin
      // Tie: round-robin hands the grant to whoever did not win last time.
      gnt_id_c = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else if (valid1) begin
      gnt_id_c = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single dmem port between the datapath (requester 0) and the
// debug/program loader (requester 1).
//   clk, rst_n             : clock, async active-low reset
//   reqN_valid/ready       : request handshake (ready combinational, IDLE only)
//   reqN_addr/wdata/we     : request payload, sampled on the handshake edge
//   rspN_valid/rdata/err   : one-cycle response pulse for the owning requester
//   addr_to_dmem, store_data_to_dmem, store_we_to_dmem : memory port drive
//   load_data_from_dmem    : memory port read data
// One transaction in flight at a time: IDLE -> ACCESS (MEM_LATENCY cycles)
// -> RESP (1 cycle) -> IDLE. Misaligned requests skip ACCESS entirely.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_addr,
  input  logic [XLEN-1:0] req0_wdata,
  input  logic [WE_W-1:0] req0_we,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_rdata,
  output logic            rsp0_err,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_addr,
  input  logic [XLEN-1:0] req1_wdata,
  input  logic [WE_W-1:0] req1_we,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_rdata,
  output logic            rsp1_err,

  output logic [XLEN-1:0] addr_to_dmem,
  output logic [XLEN-1:0] store_data_to_dmem,
  output logic [WE_W-1:0] store_we_to_dmem,
  input  logic [XLEN-1:0] load_data_from_dmem
);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LATENCY - 1);

  arb_state_t      state_q, state_d;
  req_id_t         last_grant_q, last_grant_d;
  req_id_t         id_q, id_d;
  mem_req_t        req_q, req_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            gnt_any_c;
  req_id_t         gnt_id_c;
  mem_req_t        req0_bus, req1_bus, sel_req;

  assign req0_bus = '{addr: req0_addr, wdata: req0_wdata, we: req0_we};
  assign req1_bus = '{addr: req1_addr, wdata: req1_wdata, we: req1_we};
  assign sel_req  = gnt_id_c ? req1_bus : req0_bus;

  // Arbitration between the two requesters.
  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .gnt_any_c  (gnt_any_c),
    .gnt_id_c   (gnt_id_c)
  );

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      req_q        <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      req_q        <= req_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
    end
  end

  // Next-state logic and output muxing.
  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    id_d               = id_q;
    req_d              = req_q;
    err_d              = err_q;
    cnt_d              = cnt_q;
    data_d             = data_q;

    req0_ready         = 1'b0;
    req1_ready         = 1'b0;
    rsp0_valid         = 1'b0;
    rsp1_valid         = 1'b0;
    rsp0_rdata         = '0;
    rsp1_rdata         = '0;
    rsp0_err           = 1'b0;
    rsp1_err           = 1'b0;
    addr_to_dmem       = '0;
    store_data_to_dmem = '0;
    store_we_to_dmem   = '0;

    unique case (state_q)
      IDLE: begin
        // Ready is held low while reset is asserted even with valid high.
        if (rst_n && gnt_any_c) begin
          req0_ready   = (gnt_id_c == 1'b0);
          req1_ready   = (gnt_id_c == 1'b1);
          id_d         = gnt_id_c;
          last_grant_d = gnt_id_c;
          req_d        = sel_req;
          err_d        = is_misaligned(sel_req.addr);
          data_d       = '0;
          cnt_d        = CNT_START;
          state_d      = is_misaligned(sel_req.addr) ? RESP : ACCESS;
        end
      end

      ACCESS: begin
        addr_to_dmem       = word_align(req_q.addr);
        store_data_to_dmem = req_q.wdata;
        // Byte enables only in the first access cycle: one write per store.
        if (cnt_q == CNT_START) begin
          store_we_to_dmem = req_q.we;
        end
        if (cnt_q == '0) begin
          data_d  = (req_q.we == '0) ? load_data_from_dmem : '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        rsp0_valid = (id_q == 1'b0);
        rsp1_valid = (id_q == 1'b1);
        rsp0_rdata = (id_q == 1'b0) ? data_q : '0;
        rsp1_rdata = (id_q == 1'b1) ? data_q : '0;
        rsp0_err   = (id_q == 1'b0) && err_q;
        rsp1_err   = (id_q == 1'b1) && err_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Three instances:
//   k=0 : MEM_LATENCY=1, round-robin
//   k=1 : MEM_LATENCY=1, fixed priority
//   k=2 : MEM_LATENCY=3, round-robin
// Each instance has its own word-addressed memory model.
module tb_dmem_port_arbiter;

  logic clk;
  logic rst_n;

  logic [2:0]  r0v, r1v, r0rdy, r1rdy, s0v, s1v, s0e, s1e;
  logic [31:0] r0a [3];
  logic [31:0] r1a [3];
  logic [31:0] r0d [3];
  logic [31:0] r1d [3];
  logic [3:0]  r0w [3];
  logic [3:0]  r1w [3];
  logic [31:0] s0d [3];
  logic [31:0] s1d [3];
  logic [31:0] maddr [3];
  logic [31:0] mdat [3];
  logic [31:0] ldat [3];
  logic [3:0]  mwe [3];

  logic [31:0] mem [3][256];
  int          wcnt [3] = '{0, 0, 0};
  logic        bd_we;
  int          bd_k;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  int checks   = 0;
  int failures = 0;
  int base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    dmem_port_arbiter #(
      .MEM_LATENCY ((k == 2) ? 3 : 1),
      .FIXED_PRIO  (k == 1)
    ) u_dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .req0_valid          (r0v[k]),
      .req0_ready          (r0rdy[k]),
      .req0_addr           (r0a[k]),
      .req0_wdata          (r0d[k]),
      .req0_we             (r0w[k]),
      .rsp0_valid          (s0v[k]),
      .rsp0_rdata          (s0d[k]),
      .rsp0_err            (s0e[k]),
      .req1_valid          (r1v[k]),
      .req1_ready          (r1rdy[k]),
      .req1_addr           (r1a[k]),
      .req1_wdata          (r1d[k]),
      .req1_we             (r1w[k]),
      .rsp1_valid          (s1v[k]),
      .rsp1_rdata          (s1d[k]),
      .rsp1_err            (s1e[k]),
      .addr_to_dmem        (maddr[k]),
      .store_data_to_dmem  (mdat[k]),
      .store_we_to_dmem    (mwe[k]),
      .load_data_from_dmem (ldat[k])
    );
    assign ldat[k] = mem[k][maddr[k][9:2]];
  end

  // Memory models: byte-enable writes, backdoor preload, write-cycle count.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (bd_we && bd_k == k) begin
        mem[k][bd_idx] <= bd_data;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mwe[k][b]) mem[k][maddr[k][9:2]][8*b +: 8] <= mdat[k][8*b +: 8];
        end
      end
      if (mwe[k] != 4'h0) wcnt[k] <= wcnt[k] + 1;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    r0v    = '0;
    r1v    = '0;
    bd_we  = 1'b0;
    bd_k   = 0;
    bd_idx = '0;
    bd_data = '0;
    for (int k = 0; k < 3; k++) begin
      r0a[k] = '0; r1a[k] = '0; r0d[k] = '0; r1d[k] = '0; r0w[k] = '0; r1w[k] = '0;
    end

    // Reset: readies stay low even with valids raised, port idle.
    @(negedge clk);
    r0v = 3'b111;
    r1v = 3'b111;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1("rst_ready0", r0rdy[k], 1'b0);
      chk1("rst_ready1", r1rdy[k], 1'b0);
      chk1("rst_rsp0", s0v[k], 1'b0);
      chk1("rst_rsp1", s1v[k], 1'b0);
      chk32("rst_we", 32'(mwe[k]), 32'h0);
      chk32("rst_addr", maddr[k], 32'h0);
    end
    r0v = '0;
    r1v = '0;
    bd_we = 1'b1; bd_k = 0; bd_idx = 8'd64; bd_data = 32'hDEADBEEF;
    @(negedge clk);
    bd_we = 1'b0;
    rst_n = 1'b1;

    // Round-robin tie on k=0: grants alternate 0,1,0,1, response two cycles on.
    @(negedge clk);
    r0v[0] = 1'b1; r0a[0] = 32'h200; r0w[0] = 4'h0;
    r1v[0] = 1'b1; r1a[0] = 32'h204; r1w[0] = 4'h0;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk1("rr_ready0", r0rdy[0], (g % 2) == 0);
      chk1("rr_ready1", r1rdy[0], (g % 2) == 1);
      @(negedge clk); #1;
      chk1("rr_acc_ready_both", r0rdy[0] | r1rdy[0], 1'b0);
      chk32("rr_acc_addr", maddr[0], ((g % 2) == 0) ? 32'h200 : 32'h204);
      chk1("rr_acc_rsp", s0v[0] | s1v[0], 1'b0);
      @(negedge clk); #1;
      chk1("rr_rsp0", s0v[0], (g % 2) == 0);
      chk1("rr_rsp1", s1v[0], (g % 2) == 1);
      chk1("rr_resp_ready_both", r0rdy[0] | r1rdy[0], 1'b0);
      if (g == 3) begin
        r0v[0] = 1'b0;
        r1v[0] = 1'b0;
      end
      @(negedge clk);
    end

    // Lone load of 0xDEADBEEF from 0x100 on k=0.
    r0v[0] = 1'b1; r0a[0] = 32'h100; r0w[0] = 4'h0;
    #1;
    chk1("ld_ready0", r0rdy[0], 1'b1);
    chk1("ld_ready1", r1rdy[0], 1'b0);
    @(negedge clk);
    r0v[0] = 1'b0;
    #1;
    chk32("ld_acc_we", 32'(mwe[0]), 32'h0);
    chk32("ld_acc_addr", maddr[0], 32'h100);
    chk1("ld_acc_rsp0", s0v[0], 1'b0);
    @(negedge clk); #1;
    chk1("ld_rsp0", s0v[0], 1'b1);
    chk32("ld_rdata", s0d[0], 32'hDEADBEEF);
    chk1("ld_err", s0e[0], 1'b0);
    chk1("ld_rsp1", s1v[0], 1'b0);
    @(negedge clk); #1;
    chk1("ld_rsp0_drop", s0v[0], 1'b0);

    // Store by req1 then load by req0, same address, both raised together.
    base = wcnt[0];
    r1v[0] = 1'b1; r1a[0] = 32'h40; r1d[0] = 32'h12345678; r1w[0] = 4'hF;
    r0v[0] = 1'b1; r0a[0] = 32'h40; r0w[0] = 4'h0;
    #1;
    chk1("sl_ready1", r1rdy[0], 1'b1);
    chk1("sl_ready0", r0rdy[0], 1'b0);
    @(negedge clk);
    r1v[0] = 1'b0;
    #1;
    chk32("sl_we", 32'(mwe[0]), 32'hF);
    chk32("sl_addr", maddr[0], 32'h40);
    chk32("sl_wdata", mdat[0], 32'h12345678);
    chk1("sl_acc_ready0", r0rdy[0], 1'b0);
    @(negedge clk); #1;
    chk1("sl_rsp1", s1v[0], 1'b1);
    chk32("sl_rsp1_rdata", s1d[0], 32'h0);
    chk32("sl_resp_we", 32'(mwe[0]), 32'h0);
    chk1("sl_resp_rsp0", s0v[0], 1'b0);
    @(negedge clk); #1;
    chk1("sl_ready0_2nd", r0rdy[0], 1'b1);
    @(negedge clk);
    r0v[0] = 1'b0;
    #1;
    chk32("sl_ld_we", 32'(mwe[0]), 32'h0);
    @(negedge clk); #1;
    chk1("sl_rsp0", s0v[0], 1'b1);
    chk32("sl_rsp0_rdata", s0d[0], 32'h12345678);
    chk32("sl_write_count", 32'(wcnt[0] - base), 32'd1);

    // Misaligned store: error response next cycle, no write.
    @(negedge clk);
    base = wcnt[0];
    r0v[0] = 1'b1; r0a[0] = 32'h102; r0d[0] = 32'hAAAAAAAA; r0w[0] = 4'h3;
    #1;
    chk1("mis_ready0", r0rdy[0], 1'b1);
    @(negedge clk);
    r0v[0] = 1'b0;
    #1;
    chk1("mis_rsp0", s0v[0], 1'b1);
    chk1("mis_err", s0e[0], 1'b1);
    chk32("mis_rdata", s0d[0], 32'h0);
    chk32("mis_we", 32'(mwe[0]), 32'h0);
    chk32("mis_addr", maddr[0], 32'h0);
    @(negedge clk); #1;
    chk1("mis_rsp0_drop", s0v[0], 1'b0);
    chk1("mis_err_drop", s0e[0], 1'b0);
    chk32("mis_write_count", 32'(wcnt[0] - base), 32'd0);
    chk32("mis_mem", mem[0][64], 32'hDEADBEEF);

    // Fixed priority on k=1: req1 starved while req0 stays valid.
    r0v[1] = 1'b1; r0a[1] = 32'h10; r0w[1] = 4'h0;
    r1v[1] = 1'b1; r1a[1] = 32'h14; r1w[1] = 4'h0;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk1("fp_ready0", r0rdy[1], 1'b1);
      chk1("fp_ready1", r1rdy[1], 1'b0);
      @(negedge clk);
      @(negedge clk); #1;
      chk1("fp_rsp0", s0v[1], 1'b1);
      chk1("fp_rsp1", s1v[1], 1'b0);
      if (g == 2) r0v[1] = 1'b0;
      @(negedge clk);
    end
    #1;
    chk1("fp_ready1_after", r1rdy[1], 1'b1);
    chk1("fp_ready0_after", r0rdy[1], 1'b0);
    @(negedge clk);
    r1v[1] = 1'b0;
    @(negedge clk); #1;
    chk1("fp_rsp1_after", s1v[1], 1'b1);

    // k=2, latency 3: reset in the first access cycle drops the write enable at once.
    @(negedge clk);
    r0v[2] = 1'b1; r0a[2] = 32'h80; r0d[2] = 32'h55; r0w[2] = 4'hF;
    #1;
    chk1("ab1_ready0", r0rdy[2], 1'b1);
    @(negedge clk);
    r0v[2] = 1'b0;
    #1;
    chk32("ab1_we_before", 32'(mwe[2]), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk32("ab1_we_async", 32'(mwe[2]), 32'h0);
    chk32("ab1_addr_async", maddr[2], 32'h0);
    base = wcnt[2];
    @(negedge clk);
    rst_n = 1'b1;

    // Store again, then abort in the second access cycle with both valid.
    r0v[2] = 1'b1;
    #1;
    chk1("ab2_ready0", r0rdy[2], 1'b1);
    @(negedge clk);
    r1v[2] = 1'b1; r1a[2] = 32'h84; r1w[2] = 4'h0;
    #1;
    chk32("ab2_we_cyc1", 32'(mwe[2]), 32'hF);
    chk1("ab2_acc_ready", r0rdy[2] | r1rdy[2], 1'b0);
    @(negedge clk); #1;
    chk32("ab2_we_cyc2", 32'(mwe[2]), 32'h0);
    chk32("ab2_addr_cyc2", maddr[2], 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk1("ab2_ready_rst", r0rdy[2] | r1rdy[2], 1'b0);
    chk32("ab2_we_rst", 32'(mwe[2]), 32'h0);
    chk32("ab2_addr_rst", maddr[2], 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk1("ab2_no_rsp0", s0v[2], 1'b0);
      chk1("ab2_no_rsp1", s1v[2], 1'b0);
    end
    chk32("ab2_write_count", 32'(wcnt[2] - base), 32'd1);

    // After release the first tie goes to req0; load sees the completed write.
    @(negedge clk);
    rst_n = 1'b1;
    r0w[2] = 4'h0;
    #1;
    chk1("post_ready0", r0rdy[2], 1'b1);
    chk1("post_ready1", r1rdy[2], 1'b0);
    @(negedge clk);
    r0v[2] = 1'b0;
    r1v[2] = 1'b0;
    #1;
    chk1("post_acc1_rsp0", s0v[2], 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    chk1("post_acc3_rsp0", s0v[2], 1'b0);
    chk32("post_acc3_we", 32'(mwe[2]), 32'h0);
    @(negedge clk); #1;
    chk1("post_rsp0", s0v[2], 1'b1);
    chk32("post_rdata", s0d[2], 32'h00000055);
    chk1("post_rsp1", s1v[2], 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
